// File: rtl/alu_arbiter_if.sv
// Bundle of the requester, shared-ALU and response signals of alu_arbiter.
// The slave modport is the arbiter's view; master is the view of the
// environment (requesters, ALU and response consumer).
// Optional feature macro: ALU_ARBITER_LOCK_EN adds req_lock.
interface alu_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  // Requester side
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ*4-1:0]  req_op;
`ifdef ALU_ARBITER_LOCK_EN
  logic [NREQ-1:0]    req_lock;
`endif

  // Shared combinational ALU
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_carry;
  logic        alu_overflow;

  // Response side
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [31:0]    rsp_result;
  logic           rsp_zero;
  logic           rsp_carry;
  logic           rsp_overflow;

  modport slave (
    input  req_valid, req_a, req_b, req_op,
`ifdef ALU_ARBITER_LOCK_EN
    input  req_lock,
`endif
    output req_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_zero, alu_carry, alu_overflow,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_overflow,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_a, req_b, req_op,
`ifdef ALU_ARBITER_LOCK_EN
    output req_lock,
`endif
    input  req_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_zero, alu_carry, alu_overflow,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_overflow,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters,
// with a single registered response slot.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Requesters may drop valid at any time without penalty; a
// response, once valid, holds all rsp_* fields stable until rsp_ready.
//
// Optional feature macro: ALU_ARBITER_LOCK_EN (requester lock for atomic
// multi-op sequences). Default build is plain round-robin.
module alu_arbiter #(
  parameter int NREQ = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_arbiter_if.slave   bus,
  output logic           dbg_state
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e         state_q;
  state_e         state_d;
  logic [IDW-1:0] last_grant_q;
  logic [NREQ-1:0] eligible;
  logic           gnt_found;
  int             gnt_int;
  logic [IDW-1:0] gnt_idx;
  logic           accept_en;
  logic           accept;

  logic [IDW-1:0] rsp_id_q;
  logic [31:0]    rsp_result_q;
  logic           rsp_zero_q;
  logic           rsp_carry_q;
  logic           rsp_overflow_q;

`ifdef ALU_ARBITER_LOCK_EN
  logic           lock_q;
  logic [IDW-1:0] lock_owner_q;

  // While locked, only the owner is eligible; others stall even if it idles.
  always_comb begin
    eligible = bus.req_valid;
    if (lock_q) eligible = bus.req_valid & (NREQ'(1) << lock_owner_q);
  end
`else
  // Every valid requester competes.
  always_comb begin
    eligible = bus.req_valid;
  end
`endif

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_int   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant_q) + k) % NREQ;
      if (!gnt_found && eligible[idx]) begin
        gnt_found = 1'b1;
        gnt_int   = idx;
      end
    end
    gnt_idx = IDW'(gnt_int);
  end

  // A new op can be taken when the slot is empty or is draining this cycle.
  assign accept_en = (state_q == ST_EMPTY) || bus.rsp_ready;
  assign accept    = gnt_found && accept_en && rst_n;

  // One-hot ready to the granted requester, only when it will be accepted.
  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[gnt_int] = 1'b1;
  end

  // Drive the shared ALU from the granted requester; zeros/ADD when idle.
  always_comb begin
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    bus.alu_op = 4'd0;
    if (gnt_found) begin
      bus.alu_a  = bus.req_a[32*gnt_int +: 32];
      bus.alu_b  = bus.req_b[32*gnt_int +: 32];
      bus.alu_op = bus.req_op[4*gnt_int +: 4];
    end
  end

  // Response slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Response slot next state: fill on accept, empty on drain without refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (bus.rsp_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Capture ALU outputs and owner on every accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_q       <= '0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_carry_q    <= 1'b0;
      rsp_overflow_q <= 1'b0;
    end else if (accept) begin
      rsp_id_q       <= gnt_idx;
      rsp_result_q   <= bus.alu_result;
      rsp_zero_q     <= bus.alu_zero;
      rsp_carry_q    <= bus.alu_carry;
      rsp_overflow_q <= bus.alu_overflow;
    end
  end

  // Round-robin pointer moves only on accepted transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant_q <= IDW'(NREQ - 1);
    else if (accept) last_grant_q <= gnt_idx;
  end

`ifdef ALU_ARBITER_LOCK_EN
  // Lock follows the lock bit of each accepted request; since only the owner
  // can be granted while locked, an unlocked accept by it releases the lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q       <= 1'b0;
      lock_owner_q <= '0;
    end else if (accept) begin
      lock_q       <= bus.req_lock[gnt_int];
      lock_owner_q <= gnt_idx;
    end
  end
`endif

  assign bus.rsp_valid    = (state_q == ST_FULL);
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_carry    = rsp_carry_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign dbg_state        = state_q;

endmodule
